// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: two-requester (floppy / hard disk) sector request arbiter
// in front of the SPI user IO block. A round-robin pick in IDLE latches the
// owner, address and command. The command is held until sd_ack rises, and
// completion is signalled when sd_ack falls.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort a stuck transaction
// after 2^TIMEOUT_W-1 cycles in ISSUE/XFER with an err pulse.
module sd_req_arbiter #(
   parameter int unsigned TIMEOUT_W = 24
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [1:0]  req_rd,
   input  logic [1:0]  req_wr,
   input  logic [31:0] req_lba0,
   input  logic [31:0] req_lba1,
   input  logic        sd_ack,
   output logic [1:0]  sd_rd,
   output logic [1:0]  sd_wr,
   output logic [31:0] sd_lba,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [1:0]  err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  sd_rd_q, sd_rd_d;
   logic [1:0]  sd_wr_q, sd_wr_d;
   logic [31:0] sd_lba_q, sd_lba_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  done_q, done_d;
   logic        last_owner_q, last_owner_d;

   logic [1:0]  pending;
   logic        sel;
   logic        owner;
   logic        timeout_hit;

   // Pending requesters; the one that did not own the last transaction is
   // preferred, so continuous requests alternate.
   assign pending = req_rd | req_wr;
   assign sel     = pending[~last_owner_q] ? ~last_owner_q : last_owner_q;
   assign owner   = gnt_q[1];

`ifdef SD_ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdog_inc;
   logic [1:0]           err_q, err_d;

   assign wdog_inc    = wdog_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   // Fires on the cycle the counter would reach all-ones.
   assign timeout_hit = ((state_q == S_ISSUE) || (state_q == S_XFER)) && (&wdog_inc);

   // Watchdog: cleared when a grant is taken, counts while busy, saturates.
   always_comb begin
      wdog_d = wdog_q;
      err_d  = '0;
      if ((state_q == S_IDLE) && (|pending)) begin
         wdog_d = '0;
      end else if ((state_q == S_ISSUE) || (state_q == S_XFER)) begin
         wdog_d = (&wdog_q) ? wdog_q : wdog_inc;
      end
      if (timeout_hit) begin
         err_d[owner] = 1'b1;
      end
   end

   // Watchdog and err pulse registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wdog_q <= '0;
         err_q  <= '0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = '0;
`endif

   // State and datapath registers; reset drops every output at once.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         sd_rd_q      <= '0;
         sd_wr_q      <= '0;
         sd_lba_q     <= '0;
         gnt_q        <= '0;
         done_q       <= '0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         sd_rd_q      <= sd_rd_d;
         sd_wr_q      <= sd_wr_d;
         sd_lba_q     <= sd_lba_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         last_owner_q <= last_owner_d;
      end
   end

   // Next-state: grant, wait for ack high, wait for ack low, complete.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|pending) state_d = S_ISSUE;
         S_ISSUE: if (timeout_hit) state_d = S_IDLE;
                  else if (sd_ack) state_d = S_XFER;
         S_XFER:  if (timeout_hit) state_d = S_IDLE;
                  else if (!sd_ack) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: latch owner/address/command at grant, hold them until the
   // transaction ends; request inputs are ignored outside IDLE.
   always_comb begin
      sd_rd_d      = sd_rd_q;
      sd_wr_d      = sd_wr_q;
      sd_lba_d     = sd_lba_q;
      gnt_d        = gnt_q;
      done_d       = '0;
      last_owner_d = last_owner_q;
      case (state_q)
         S_IDLE: begin
            if (|pending) begin
               gnt_d    = 2'b01 << sel;
               sd_lba_d = sel ? req_lba1 : req_lba0;
               // Read wins; a simultaneous write stays pending.
               if (req_rd[sel]) sd_rd_d[sel] = 1'b1;
               else             sd_wr_d[sel] = 1'b1;
            end
         end
         S_ISSUE, S_XFER: begin
            if (timeout_hit) begin
               sd_rd_d      = '0;
               sd_wr_d      = '0;
               gnt_d        = '0;
               last_owner_d = owner;
            end else if ((state_q == S_ISSUE) && sd_ack) begin
               sd_rd_d = '0;
               sd_wr_d = '0;
            end
         end
         S_DONE: begin
            done_d[owner] = 1'b1;
            gnt_d         = '0;
            last_owner_d  = owner;
         end
         default: ;
      endcase
   end

   assign sd_rd  = sd_rd_q;
   assign sd_wr  = sd_wr_q;
   assign sd_lba = sd_lba_q;
   assign gnt    = gnt_q;
   assign done   = done_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter with an expected-transaction scoreboard.
module tb_sd_req_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
   localparam int unsigned TW = 4;
`else
   localparam int unsigned TW = 24;
`endif

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_rd = '0, req_wr = '0;
   logic [31:0] req_lba0 = '0, req_lba1 = '0;
   logic        sd_ack = 1'b0;
   logic [1:0]  sd_rd, sd_wr, gnt, done, err;
   logic [31:0] sd_lba;

   typedef struct {
      logic [1:0]  gnt;
      logic [1:0]  rd;
      logic [1:0]  wr;
      logic [31:0] lba;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_chk = 0, n_pass = 0;
   int   done_cnt = 0, err_cnt = 0;

   sd_req_arbiter #(.TIMEOUT_W(TW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
      .req_lba0(req_lba0), .req_lba1(req_lba1), .sd_ack(sd_ack),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .gnt(gnt),
      .done(done), .err(err)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Pulse counters and the never-two-commands property.
   always @(negedge clk_sys) begin
      if (done != 2'b00) done_cnt++;
      if (err != 2'b00) err_cnt++;
      if (reset_n) begin
         check("cmd_onehot", 64'($countones(sd_rd | sd_wr) <= 1), 64'd1);
`ifndef SD_ARB_TIMEOUT_EN
         check("err_tied0", 64'(err), 64'd0);
`endif
      end
   end

   task automatic do_reset();
      @(negedge clk_sys);
      reset_n = 1'b0;
      req_rd = '0; req_wr = '0; sd_ack = 1'b0;
      #1;
      check("rst_ctl", 64'({sd_rd, sd_wr, gnt, done, err}), 64'd0);
      check("rst_lba", 64'(sd_lba), 64'd0);
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   // Wait for a command, compare it with the scoreboard head, then ack it.
   task automatic issue_phase(input int ack_dly, output int lat);
      int k = 0;
      while ((sd_rd | sd_wr) == 2'b00 && k < 10) begin
         @(negedge clk_sys);
         k++;
      end
      lat = k;
      check("issue_seen", 64'((sd_rd | sd_wr) != 2'b00), 64'd1);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      check("issue_gnt", 64'(gnt), 64'(cur.gnt));
      check("issue_rd", 64'(sd_rd), 64'(cur.rd));
      check("issue_wr", 64'(sd_wr), 64'(cur.wr));
      check("issue_lba", 64'(sd_lba), 64'(cur.lba));
      repeat (ack_dly) @(negedge clk_sys);
      check("cmd_held", 64'({sd_rd, sd_wr}), 64'({cur.rd, cur.wr}));
      sd_ack = 1'b1;
      @(negedge clk_sys);
      check("cmd_clr", 64'({sd_rd, sd_wr}), 64'd0);
      check("xfer_gnt", 64'(gnt), 64'(cur.gnt));
   endtask

   // Drop ack after xfer_len cycles and wait for the done pulse.
   task automatic finish_phase(input int xfer_len);
      int k = 0;
      repeat (xfer_len) @(negedge clk_sys);
      sd_ack = 1'b0;
      while (done == 2'b00 && k < 10) begin
         @(negedge clk_sys);
         k++;
      end
      check("done_val", 64'(done), 64'(cur.gnt));
      check("done_gnt_clr", 64'(gnt), 64'd0);
      check("done_lba", 64'(sd_lba), 64'(cur.lba));
   endtask

   task automatic push(input logic [1:0] g, input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] l);
      exp_t e;
      e.gnt = g; e.rd = r; e.wr = w; e.lba = l;
      exp_q.push_back(e);
   endtask

   initial begin
      int lat, d0;
      // Reset state
      do_reset();

      // Single read from requester 0; withdrawal and address change after
      // grant must not disturb it.
      @(negedge clk_sys);
      req_rd = 2'b01; req_lba0 = 32'h0000_0123;
      push(2'b01, 2'b01, 2'b00, 32'h0000_0123);
      issue_phase(4, lat);
      check("rd_latency", 64'(lat), 64'd1);
      req_rd = 2'b00; req_lba0 = 32'hDEAD_BEEF;
      finish_phase(20);
      @(negedge clk_sys);
      check("done_1cyc", 64'(done), 64'd0);
      check("no_regrant", 64'(gnt), 64'd0);

      // Simultaneous writes from reset: 0 then 1, two done pulses
      do_reset();
      req_wr = 2'b11; req_lba0 = 32'h0000_1000; req_lba1 = 32'h0000_2000;
      push(2'b01, 2'b00, 2'b01, 32'h0000_1000);
      push(2'b10, 2'b00, 2'b10, 32'h0000_2000);
      d0 = done_cnt;
      issue_phase(2, lat);
      finish_phase(3);
      req_wr[0] = 1'b0;
      issue_phase(2, lat);
      finish_phase(3);
      req_wr[1] = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("two_dones", 64'(done_cnt - d0), 64'd2);

      // Continuous reads from both: grants alternate 01,10,01,10
      req_rd = 2'b11; req_lba0 = 32'hA0A0_0000; req_lba1 = 32'hB1B1_0001;
      for (int i = 0; i < 2; i++) begin
         push(2'b01, 2'b01, 2'b00, 32'hA0A0_0000);
         push(2'b10, 2'b10, 2'b00, 32'hB1B1_0001);
      end
      for (int i = 0; i < 4; i++) begin
         issue_phase(1, lat);
         finish_phase(2);
      end
      req_rd = 2'b00;
      @(negedge clk_sys);
      check("rr_done_1cyc", 64'(done), 64'd0);

      // Read and write together on requester 1: read first
      req_rd = 2'b10; req_wr = 2'b10; req_lba1 = 32'h0055_AA00;
      push(2'b10, 2'b10, 2'b00, 32'h0055_AA00);
      push(2'b10, 2'b00, 2'b10, 32'h0055_AA00);
      issue_phase(1, lat);
      req_lba1 = 32'h1234_5678;
      finish_phase(2);
      req_rd[1] = 1'b0;
      req_lba1 = 32'h0055_AA00;
      issue_phase(1, lat);
      finish_phase(2);
      req_wr[1] = 1'b0;
      @(negedge clk_sys);

      // Complete one for requester 0, then reset in the middle of a
      // requester 1 transfer; the next grant still goes to requester 0.
      req_rd = 2'b01; req_lba0 = 32'h0000_0777;
      push(2'b01, 2'b01, 2'b00, 32'h0000_0777);
      issue_phase(1, lat);
      finish_phase(1);
      req_rd = 2'b10; req_lba1 = 32'h0000_0888;
      push(2'b10, 2'b10, 2'b00, 32'h0000_0888);
      issue_phase(1, lat);
      repeat (2) @(negedge clk_sys);
      d0 = done_cnt + err_cnt;
      do_reset();
      repeat (3) @(negedge clk_sys);
      check("rst_no_pulse", 64'(done_cnt + err_cnt), 64'(d0));
      req_rd = 2'b11; req_lba0 = 32'h0000_0999; req_lba1 = 32'h0000_0AAA;
      push(2'b01, 2'b01, 2'b00, 32'h0000_0999);
      push(2'b10, 2'b10, 2'b00, 32'h0000_0AAA);
      issue_phase(1, lat);
      finish_phase(1);
      req_rd[0] = 1'b0;
      issue_phase(1, lat);
      finish_phase(1);
      req_rd = 2'b00;
      @(negedge clk_sys);

`ifdef SD_ARB_TIMEOUT_EN
      // Watchdog: ack never comes, err after 15 cycles in ISSUE
      req_rd = 2'b01; req_lba0 = 32'h0000_0ABC;
      lat = 0;
      while (sd_rd == 2'b00 && lat < 10) begin
         @(negedge clk_sys);
         lat++;
      end
      check("to_issue", 64'(sd_rd), 64'd1);
      d0 = done_cnt;
      lat = 0;
      while (err == 2'b00 && lat < 30) begin
         @(negedge clk_sys);
         lat++;
      end
      check("to_latency", 64'(lat), 64'd15);
      check("to_err", 64'(err), 64'd1);
      check("to_cmd_clr", 64'({sd_rd, sd_wr}), 64'd0);
      check("to_gnt_clr", 64'(gnt), 64'd0);
      req_rd = 2'b00;
      @(negedge clk_sys);
      check("to_err_1cyc", 64'(err), 64'd0);
      check("to_no_done", 64'(done_cnt), 64'(d0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 24: width of the watchdog counter, so timeout = 2^TIMEOUT_W-1 cycles.
REQ-002 SHALL have port clk_sys, input, 1 bit: system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_rd, input, 2 bits: sector read request per requester (0 = floppy, 1 = hard disk), held level-high until done.
REQ-005 SHALL have port req_wr, input, 2 bits: sector write request per requester, held level-high until done.
REQ-006 SHALL have ports req_lba0 and req_lba1, input, 32 bits each: sector address of requester 0 and requester 1.
REQ-007 SHALL have port sd_ack, input, 1 bit: transfer-active flag from the SPI user IO block.
REQ-008 SHALL have port sd_rd, output, 2 bits: read command to the SPI user IO block; bit index = drive.
REQ-009 SHALL have port sd_wr, output, 2 bits: write command to the SPI user IO block; bit index = drive.
REQ-010 SHALL have port sd_lba, output, 32 bits: latched sector address.
REQ-011 SHALL have port gnt, output, 2 bits: one-hot owner of the current transaction.
REQ-012 SHALL have port done, output, 2 bits: one-cycle completion pulse per requester.
REQ-013 SHALL have port err, output, 2 bits: one-cycle timeout pulse per requester.

Function
REQ-014 SHALL implement states IDLE, ISSUE, XFER, DONE.
REQ-015 IDLE: a requester is pending when req_rd|req_wr is set; the pending requester SHALL be selected round-robin, preferring the requester other than last_owner.
REQ-016 On selection in cycle N, the block SHALL register gnt, sd_lba, and exactly one bit of sd_rd or sd_wr (bit = requester index), visible in cycle N+1, and SHALL move to ISSUE.
REQ-017 When req_rd and req_wr are both set for the same requester, read SHALL win; the write SHALL stay pending.
REQ-018 ISSUE: sd_rd/sd_wr SHALL stay asserted until sd_ack=1 is sampled; on that edge it SHALL clear sd_rd/sd_wr and move to XFER.
REQ-019 XFER: on sampling sd_ack=0 the block SHALL move to DONE.
REQ-020 DONE: the block SHALL pulse done[owner] for one cycle, clear gnt, update last_owner, and return to IDLE; a new grant SHALL issue no earlier than the following cycle.
REQ-021 sd_lba and the command type SHALL be latched at grant; changes to req_* or req_lba* after grant SHALL be ignored until DONE.
REQ-022 A request withdrawn after grant SHALL NOT abort the transaction.
REQ-023 At most one bit across sd_rd|sd_wr SHALL ever be set.

Reset
REQ-024 While reset_n=0: state=IDLE; sd_rd, sd_wr, gnt, done, err=0; sd_lba=0; watchdog=0; last_owner=1, so requester 0 wins first.
REQ-025 Reset asserted mid-transaction SHALL drop sd_rd/sd_wr immediately (asynchronously) and SHALL NOT emit done or err.

Configuration
REQ-026 Macro SD_ARB_TIMEOUT_EN defined: the watchdog SHALL clear on entry to ISSUE, increment each cycle in ISSUE/XFER, and saturate at all-ones.
REQ-027 On saturation (SD_ARB_TIMEOUT_EN defined), the block SHALL pulse err[owner] for one cycle, clear sd_rd/sd_wr/gnt, update last_owner, and return to IDLE without done.
REQ-028 Macro SD_ARB_TIMEOUT_EN undefined: no watchdog logic SHALL be present, err SHALL be tied to 0, and ISSUE/XFER SHALL wait indefinitely.

Verification
REQ-029 Reset release; req_rd=01, lba0=0x00000123; sd_ack rises 5 cycles later and falls 20 cycles after that -> sd_rd=01 and sd_lba=0x123 one cycle after request; sd_rd=00 after ack sampled high; done=01 for one cycle after ack falls.
REQ-030 req_wr=11 in the same cycle from reset -> requester 0 is granted (sd_wr=01) first, then requester 1 (sd_wr=10, sd_lba=lba1); exactly two done pulses.
REQ-031 Both requesters hold requests continuously across 4 transactions -> gnt sequence 01,10,01,10.
REQ-032 req_rd=10 and req_wr=10 together -> sd_rd=10 first; after done, sd_wr=10 is issued.
REQ-033 SD_ARB_TIMEOUT_EN defined, TIMEOUT_W=4, sd_ack held 0 -> err=01 pulse 15 cycles after ISSUE entry, sd_rd=00, no done.
REQ-034 reset_n pulsed low during XFER -> all outputs 0 immediately; no done/err; next grant goes to requester 0.
